// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch front end
package ifetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - prefetch FIFO of {pc, instr} entries with flush
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // Flush wins over both push and pop: a same-cycle push is dropped.
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full && !flush));

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - sequential instruction fetch with prefetch FIFO and redirect flush
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        redirect_misaligned,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);

    localparam int          CW   = $clog2(DEPTH + 1);
    localparam logic [31:0] STEP = 32'(INSTR_BYTES);

    fetch_state_t  state, state_nx;
    logic          started;
    logic [31:0]   fetch_pc, fetch_pc_nx;
    logic [31:0]   rsp_pc, rsp_pc_nx;
    logic [CW-1:0] outstanding, outstanding_nx;
    logic [CW-1:0] drop_cnt, drop_cnt_nx;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic          req_fire;
    logic [31:0]   redirect_base;
    fetch_entry_t  fifo_head, rsp_entry;

    assign redirect_base = {redirect_pc[31:2], 2'b00};
    // In-flight requests and buffered entries share one pool of DEPTH credits.
    assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_count};

    assign imem_req_valid = started && (state == RUN) && !redirect_valid && !fifo_full
                            && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fifo_push       = (state == RUN) && imem_rsp_valid;
    assign fifo_pop        = dec_valid && dec_ready;
    assign rsp_entry.pc    = rsp_pc;
    assign rsp_entry.instr = imem_rsp_data;

    assign dec_valid = !fifo_empty;
    assign dec_pc    = fifo_empty ? '0 : fifo_head.pc;
    assign dec_instr = fifo_empty ? '0 : fifo_head.instr;

    ifetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data (rsp_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_nx       = state;
        fetch_pc_nx    = fetch_pc;
        rsp_pc_nx      = rsp_pc;
        drop_cnt_nx    = drop_cnt;
        outstanding_nx = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        if (req_fire) fetch_pc_nx = fetch_pc + STEP;

        if (redirect_valid) begin
            fetch_pc_nx = redirect_base;
            rsp_pc_nx   = redirect_base;
            // A response landing in the redirect cycle is already discarded.
            drop_cnt_nx = ((state == RUN) ? outstanding : drop_cnt) - CW'(imem_rsp_valid);
            state_nx    = (drop_cnt_nx != '0) ? FLUSH : RUN;
        end else begin
            case (state)
                RUN: begin
                    if (imem_rsp_valid) rsp_pc_nx = rsp_pc + STEP;
                end
                FLUSH: begin
                    if (imem_rsp_valid) begin
                        drop_cnt_nx = drop_cnt - 1'b1;
                        if (drop_cnt == CW'(1)) state_nx = RUN;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= RUN;
            started             <= 1'b0;
            fetch_pc            <= RESET_PC;
            rsp_pc              <= RESET_PC;
            outstanding         <= '0;
            drop_cnt            <= '0;
            redirect_misaligned <= 1'b0;
        end else begin
            state               <= state_nx;
            started             <= 1'b1;
            fetch_pc            <= fetch_pc_nx;
            rsp_pc              <= rsp_pc_nx;
            outstanding         <= outstanding_nx;
            drop_cnt            <= drop_cnt_nx;
            redirect_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with an in-order memory model
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        redirect_misaligned;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .redirect_misaligned (redirect_misaligned),
        .imem_req_valid      (imem_req_valid),
        .imem_req_ready      (imem_req_ready),
        .imem_req_addr       (imem_req_addr),
        .imem_rsp_valid      (imem_rsp_valid),
        .imem_rsp_data       (imem_rsp_data),
        .dec_valid           (dec_valid),
        .dec_ready           (dec_ready),
        .dec_instr           (dec_instr),
        .dec_pc              (dec_pc)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int lat = 1;
    int last_due = 0;
    logic [31:0] mq[$];
    int          dq[$];

    logic        s_req_valid, s_req_fire, s_dec_valid, s_dec_fire, s_mis, s_rsp;
    logic [31:0] s_req_addr, s_dec_pc, s_dec_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // One clock: sample at negedge, accept requests into memory, drive responses after the edge.
    task automatic tick();
        int due;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_req_fire  = imem_req_valid && imem_req_ready;
        s_dec_valid = dec_valid;
        s_dec_fire  = dec_valid && dec_ready;
        s_dec_pc    = dec_pc;
        s_dec_instr = dec_instr;
        s_mis       = redirect_misaligned;
        s_rsp       = imem_rsp_valid;
        if (s_req_fire) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            mq.push_back(imem_req_addr);
            dq.push_back(due);
            last_due = due;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (dq.size() > 0 && dq[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq.pop_front());
            void'(dq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic drop_memory();
        mq.delete();
        dq.delete();
        last_due = cyc;
        imem_rsp_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        redirect_valid = 1'b0;
        drop_memory();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drop_memory();
        #1;
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); else pass_cnt++;
        total_cnt++; if (imem_req_addr !== RESET_PC) $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RESET_PC); else pass_cnt++;
        total_cnt++; if ({dec_valid, dec_pc, dec_instr, redirect_misaligned} !== '0) $display("FAIL reset_outputs: got %b/%h/%h/%b want all 0", dec_valid, dec_pc, dec_instr, redirect_misaligned); else pass_cnt++;
        tick();
        rstn = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        total_cnt++; if (s_req_valid !== 1'b0) $display("FAIL reset_first_cycle_idle: got %b want 0", s_req_valid); else pass_cnt++;
        tick();
        total_cnt++; if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) $display("FAIL reset_first_req: got %b/%h want 1/%h", s_req_valid, s_req_addr, RESET_PC); else pass_cnt++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_req, exp_dec;
        apply_reset();
        lat = 1; imem_req_ready = 1'b1; dec_ready = 1'b1;
        exp_req = RESET_PC; exp_dec = RESET_PC;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_req_fire) begin
                total_cnt++; if (s_req_addr !== exp_req) $display("FAIL seq_req_addr: got %h want %h", s_req_addr, exp_req); else pass_cnt++;
                exp_req += 32'd4;
            end
            if (s_dec_fire) begin
                total_cnt++; if (s_dec_pc !== exp_dec || s_dec_instr !== mem_word(exp_dec)) $display("FAIL seq_dec: got %h/%h want %h/%h", s_dec_pc, s_dec_instr, exp_dec, mem_word(exp_dec)); else pass_cnt++;
                exp_dec += 32'd4;
            end
        end
        total_cnt++; if (exp_dec < 32'd48) $display("FAIL seq_progress: got %0d decoded want >= 12", exp_dec / 4); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int fires;
        apply_reset();
        lat = 2; imem_req_ready = 1'b1; dec_ready = 1'b0;
        fires = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_req_fire) begin
                total_cnt++; if (s_req_addr !== 32'(fires * 4)) $display("FAIL bp_req_addr: got %h want %h", s_req_addr, 32'(fires * 4)); else pass_cnt++;
                fires++;
            end
        end
        total_cnt++; if (fires != DEPTH) $display("FAIL bp_req_count: got %0d want %0d", fires, DEPTH); else pass_cnt++;
        total_cnt++; if (s_req_valid !== 1'b0) $display("FAIL bp_req_held_low: got %b want 0", s_req_valid); else pass_cnt++;
        total_cnt++; if (s_dec_valid !== 1'b1 || s_dec_pc !== 32'h0) $display("FAIL bp_head: got %b/%h want 1/00000000", s_dec_valid, s_dec_pc); else pass_cnt++;
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_req_fire) begin
                total_cnt++; if (s_req_addr !== 32'h10) $display("FAIL bp_refill_addr: got %h want 00000010", s_req_addr); else pass_cnt++;
                fires++;
            end
        end
        total_cnt++; if (fires != 1) $display("FAIL bp_refill_count: got %0d want 1", fires); else pass_cnt++;
    endtask

    task automatic test_redirect_flush();
        int fires, stale, decs;
        logic [31:0] exp_dec;
        logic got_req;
        apply_reset();
        lat = 6; imem_req_ready = 1'b1; dec_ready = 1'b1;
        fires = 0;
        for (int i = 0; i < 20 && fires < 3; i++) begin
            tick();
            if (s_req_fire) fires++;
        end
        total_cnt++; if (fires != 3) $display("FAIL rf_prefill: got %0d want 3", fires); else pass_cnt++;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        tick();
        total_cnt++; if (s_req_valid !== 1'b0) $display("FAIL rf_flush_no_req: got %b want 0", s_req_valid); else pass_cnt++;
        stale = s_rsp ? 1 : 0;
        got_req = 1'b0; exp_dec = 32'h100; decs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!got_req && s_rsp) stale++;
            if (s_req_fire && !got_req) begin
                got_req = 1'b1;
                total_cnt++; if (s_req_addr !== 32'h100 || stale != 3) $display("FAIL rf_restart: got addr %h after %0d stale want 00000100 after 3", s_req_addr, stale); else pass_cnt++;
            end
            if (s_dec_fire) begin
                total_cnt++; if (s_dec_pc !== exp_dec || s_dec_instr !== mem_word(exp_dec)) $display("FAIL rf_dec: got %h/%h want %h/%h", s_dec_pc, s_dec_instr, exp_dec, mem_word(exp_dec)); else pass_cnt++;
                exp_dec += 32'd4; decs++;
            end
        end
        total_cnt++; if (!got_req || decs == 0) $display("FAIL rf_timeout: got req %b decs %0d want 1 and >0", got_req, decs); else pass_cnt++;
    endtask

    task automatic test_redirect_coincident();
        int fires, decs;
        logic [31:0] exp_dec;
        apply_reset();
        lat = 2; imem_req_ready = 1'b1; dec_ready = 1'b1;
        fires = 0;
        for (int i = 0; i < 10 && fires == 0; i++) begin
            tick();
            if (s_req_fire) fires++;
        end
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10 && !imem_rsp_valid; i++) tick();
        total_cnt++; if (imem_rsp_valid !== 1'b1) $display("FAIL rc_rsp_wait: got %b want 1", imem_rsp_valid); else pass_cnt++;
        redirect_valid = 1'b1; redirect_pc = 32'h200; imem_req_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick();
        total_cnt++; if (s_req_fire !== 1'b1 || s_req_addr !== 32'h200) $display("FAIL rc_next_req: got %b/%h want 1/00000200", s_req_fire, s_req_addr); else pass_cnt++;
        exp_dec = 32'h200; decs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_dec_fire) begin
                total_cnt++; if (s_dec_pc !== exp_dec) $display("FAIL rc_dec_pc: got %h want %h", s_dec_pc, exp_dec); else pass_cnt++;
                exp_dec += 32'd4; decs++;
            end
        end
        total_cnt++; if (decs < 4) $display("FAIL rc_progress: got %0d want >= 4", decs); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        logic got_req;
        apply_reset();
        lat = 1; imem_req_ready = 1'b1; dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        total_cnt++; if (s_mis !== 1'b0) $display("FAIL mis_early: got %b want 0", s_mis); else pass_cnt++;
        got_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                total_cnt++; if (s_mis !== 1'b1) $display("FAIL mis_pulse: got %b want 1", s_mis); else pass_cnt++;
            end
            if (i == 1) begin
                total_cnt++; if (s_mis !== 1'b0) $display("FAIL mis_single: got %b want 0", s_mis); else pass_cnt++;
            end
            if (s_req_fire && !got_req) begin
                got_req = 1'b1;
                total_cnt++; if (s_req_addr !== 32'h200) $display("FAIL mis_req_addr: got %h want 00000200", s_req_addr); else pass_cnt++;
            end
        end
        total_cnt++; if (!got_req) $display("FAIL mis_timeout: got no request want one"); else pass_cnt++;
    endtask

    task automatic test_reset_in_flush();
        int fires;
        logic got_req;
        apply_reset();
        lat = 8; imem_req_ready = 1'b1; dec_ready = 1'b1;
        fires = 0;
        for (int i = 0; i < 10 && fires < 2; i++) begin
            tick();
            if (s_req_fire) fires++;
        end
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        tick();
        total_cnt++; if (s_req_valid !== 1'b0) $display("FAIL rif_in_flush: got %b want 0", s_req_valid); else pass_cnt++;
        rstn = 1'b0;
        drop_memory();
        #1;
        total_cnt++; if (dec_valid !== 1'b0 || imem_req_addr !== RESET_PC) $display("FAIL rif_async: got %b/%h want 0/%h", dec_valid, imem_req_addr, RESET_PC); else pass_cnt++;
        tick();
        rstn = 1'b1; imem_req_ready = 1'b1;
        got_req = 1'b0;
        for (int i = 0; i < 6 && !got_req; i++) begin
            tick();
            if (s_req_fire) begin
                got_req = 1'b1;
                total_cnt++; if (s_req_addr !== RESET_PC || s_dec_valid !== 1'b0) $display("FAIL rif_restart: got %h/%b want %h/0", s_req_addr, s_dec_valid, RESET_PC); else pass_cnt++;
            end
        end
        total_cnt++; if (!got_req) $display("FAIL rif_timeout: got no request want one"); else pass_cnt++;
    endtask

    // Reference: decode sees one unbroken +4 stream from the latest redirect target.
    task automatic test_random();
        logic [31:0] exp_req, exp_dec, tgt;
        logic mis_exp, redir;
        apply_reset();
        exp_req = RESET_PC; exp_dec = RESET_PC; mis_exp = 1'b0; redir = 1'b0;
        for (int i = 0; i < 600; i++) begin
            lat = $urandom_range(1, 3);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            dec_ready = ($urandom_range(0, 9) < 7);
            redir = !redir && ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 4095));
            redirect_valid = redir; redirect_pc = tgt;
            tick();
            if (s_dec_fire) begin
                total_cnt++; if (s_dec_pc !== exp_dec || s_dec_instr !== mem_word(exp_dec)) $display("FAIL rnd_dec: got %h/%h want %h/%h", s_dec_pc, s_dec_instr, exp_dec, mem_word(exp_dec)); else pass_cnt++;
                exp_dec += 32'd4;
            end
            if (s_req_fire) begin
                total_cnt++; if (s_req_addr !== exp_req) $display("FAIL rnd_req: got %h want %h", s_req_addr, exp_req); else pass_cnt++;
                exp_req += 32'd4;
            end
            total_cnt++; if (s_mis !== mis_exp) $display("FAIL rnd_mis: got %b want %b", s_mis, mis_exp); else pass_cnt++;
            total_cnt++; if (((exp_req - exp_dec) >> 2) > DEPTH) $display("FAIL rnd_credit: got %0d in flight want <= %0d", (exp_req - exp_dec) >> 2, DEPTH); else pass_cnt++;
            mis_exp = redir && (tgt[1:0] != 2'b00);
            if (redir) begin
                exp_req = {tgt[31:2], 2'b00};
                exp_dec = {tgt[31:2], 2'b00};
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_flush();
        test_redirect_coincident();
        test_misaligned();
        test_reset_in_flush();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
